// File: rtl/reg_file_multiport.sv
// Operand register file: one handshaked write port, two registered read ports, and a bulk-clear engine that zeroes one entry per cycle.
// Latency: reads return data one cycle after rdN_en. Writes and clears update storage and reg_flat on the same edge.
// Backpressure: wr_ready drops while the clear engine is busy. Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module reg_file_multiport #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_err,
    input  logic                    rd0_en,
    input  logic [ADDR_W-1:0]       rd0_addr,
    output logic [DATA_W-1:0]       rd0_data,
    input  logic                    rd1_en,
    input  logic [ADDR_W-1:0]       rd1_addr,
    output logic [DATA_W-1:0]       rd1_data,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    clr_done,
    output logic [DATA_W*DEPTH-1:0] reg_flat
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   rd0_q, rd0_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;
    logic                wr_err_q, wr_err_d;
    logic                wr_acc;
    logic                wr_in_range;

    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign clr_done    = (state_q == DONE);
    assign wr_err      = wr_err_q;
    assign rd0_data    = rd0_q;
    assign rd1_data    = rd1_q;
    assign wr_acc      = wr_valid && wr_ready;
    assign wr_in_range = (32'(wr_addr) < DEPTH);

    // Out-of-range addresses read as zero rather than aliasing another entry.
    function automatic logic [DATA_W-1:0] rd_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) v = mem_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && wr_in_range && (addr == wr_addr)) v = wr_data;
`endif
        return v;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        wr_err_d = 1'b0;

        if (wr_acc) begin
            if (wr_in_range) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (32'(wr_addr) == i) mem_d[i] = wr_data;
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end

        if (rd0_en) rd0_d = rd_lookup(rd0_addr);
        if (rd1_en) rd1_d = rd_lookup(rd1_addr);

        // A write accepted together with clr_req still commits; the walk then zeroes it.
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (32'(idx_q) == i) mem_d[i] = '0;
                end
                if (32'(idx_q) == DEPTH - 1) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            wr_err_q <= wr_err_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < DEPTH; i++) reg_flat[i*DATA_W +: DATA_W] = mem_q[i];
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: main instance DEPTH=4, second instance DEPTH=3 for out-of-range addressing.
module tb_reg_file_multiport;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_err;
    logic        rd0_en = 1'b0;
    logic [1:0]  rd0_addr = '0;
    logic [7:0]  rd0_data;
    logic        rd1_en = 1'b0;
    logic [1:0]  rd1_addr = '0;
    logic [7:0]  rd1_data;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        clr_done;
    logic [31:0] reg_flat;

    logic        t3_wr_valid = 1'b0;
    logic        t3_wr_ready;
    logic [1:0]  t3_wr_addr = '0;
    logic [7:0]  t3_wr_data = '0;
    logic        t3_wr_err;
    logic        t3_rd0_en = 1'b0;
    logic [1:0]  t3_rd0_addr = '0;
    logic [7:0]  t3_rd0_data;
    logic        t3_rd1_en = 1'b0;
    logic [1:0]  t3_rd1_addr = '0;
    logic [7:0]  t3_rd1_data;
    logic        t3_clr_req = 1'b0;
    logic        t3_busy;
    logic        t3_clr_done;
    logic [23:0] t3_reg_flat;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp0_q[$];
    logic [7:0]  exp1_q[$];
    logic        en0_s = 1'b0;
    logic        en1_s = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [7:0] COLL = 8'h22;
`else
    localparam logic [7:0] COLL = 8'h11;
`endif

    always #5 clk = ~clk;

    reg_file_multiport #(.DATA_W(8), .DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .reg_flat(reg_flat)
    );

    reg_file_multiport #(.DATA_W(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(t3_wr_valid), .wr_ready(t3_wr_ready), .wr_addr(t3_wr_addr), .wr_data(t3_wr_data),
        .wr_err(t3_wr_err),
        .rd0_en(t3_rd0_en), .rd0_addr(t3_rd0_addr), .rd0_data(t3_rd0_data),
        .rd1_en(t3_rd1_en), .rd1_addr(t3_rd1_addr), .rd1_data(t3_rd1_data),
        .clr_req(t3_clr_req), .busy(t3_busy), .clr_done(t3_clr_done), .reg_flat(t3_reg_flat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [1:0] addr, input logic [7:0] exp);
        rd0_en   = 1'b1;
        rd0_addr = addr;
        exp0_q.push_back(exp);
    endtask

    task automatic rd1(input logic [1:0] addr, input logic [7:0] exp);
        rd1_en   = 1'b1;
        rd1_addr = addr;
        exp1_q.push_back(exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
    endtask

    // Monitor: a read enable seen at an edge means read data is due by the following negedge.
    always @(posedge clk) begin
        en0_s <= rd0_en;
        en1_s <= rd1_en;
    end

    always @(negedge clk) begin
        if (en0_s) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd0_unexpected: got %h expected no read", rd0_data);
            end else begin
                chk("rd0_data", 32'(rd0_data), 32'(exp0_q.pop_front()));
            end
        end
        if (en1_s) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd1_unexpected: got %h expected no read", rd1_data);
            end else begin
                chk("rd1_data", 32'(rd1_data), 32'(exp1_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while held in reset, then release mid-cycle.
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rd0", 32'(rd0_data), 32'h0);
        chk("rst_rd1", 32'(rd1_data), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flat", reg_flat, 32'h0);
        chk("rst_t3_flat", 32'(t3_reg_flat), 32'h0);
        chk("rst_t3_misc", {28'h0, t3_busy, t3_clr_done, t3_wr_err, |t3_rd1_data}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_t3_wr_ready", 32'(t3_wr_ready), 32'h1);
        cyc();

        // Basic write then dual read of the same entry.
        wr(2'd2, 8'hA5);
        cyc();
        wr_valid = 1'b0;
        chk("wr_flat", reg_flat, 32'h00A50000);
        chk("wr_err_inrange", 32'(wr_err), 32'h0);
        rd0(2'd2, 8'hA5);
        rd1(2'd2, 8'hA5);
        cyc();
        rd0_en = 1'b0;
        rd1_en = 1'b0;
        cyc();
        cyc();
        chk("rd0_hold", 32'(rd0_data), 32'h000000A5);

        // Same-edge write/read collision.
        wr(2'd1, 8'h11);
        cyc();
        wr(2'd1, 8'h22);
        rd0(2'd1, COLL);
        rd1(2'd1, COLL);
        cyc();
        wr_valid = 1'b0;
        rd1_en   = 1'b0;
        rd0(2'd1, 8'h22);
        cyc();
        rd0_en = 1'b0;
        cyc();

        // Bulk clear with reads and a redundant clr_req while busy.
        for (int i = 0; i < 4; i++) begin
            wr(2'(i), 8'(i + 1));
            cyc();
        end
        wr_valid = 1'b0;
        chk("fill_flat", reg_flat, 32'h04030201);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("clr_busy", 32'(busy), 32'h1);
            chk("clr_wr_ready", 32'(wr_ready), 32'h0);
            chk("clr_done_pulse", 32'(clr_done), 32'(k == 5));
            if (k == 1) rd0(2'd3, 8'h04);
            if (k == 2) begin
                rd1(2'd0, 8'h00);
                clr_req = 1'b1;
            end
            cyc();
            rd0_en  = 1'b0;
            rd1_en  = 1'b0;
            clr_req = 1'b0;
        end
        chk("clr_end_busy", 32'(busy), 32'h0);
        chk("clr_end_ready", 32'(wr_ready), 32'h1);
        chk("clr_end_done", 32'(clr_done), 32'h0);
        chk("clr_end_flat", reg_flat, 32'h0);
        cyc();
        chk("clr_req_ignored", 32'(busy), 32'h0);

        // Write together with clr_req: write lands, then the clear erases it.
        wr(2'd0, 8'hFF);
        clr_req = 1'b1;
        cyc();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        chk("wrclr_flat_wr", reg_flat, 32'h000000FF);
        chk("wrclr_busy", 32'(busy), 32'h1);
        repeat (5) cyc();
        chk("wrclr_flat_end", reg_flat, 32'h0);
        chk("wrclr_idle", 32'(busy), 32'h0);

        // Reset in the middle of a clear.
        wr(2'd3, 8'h33);
        cyc();
        wr_valid = 1'b0;
        chk("mid_fill", reg_flat, 32'h33000000);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ready", 32'(wr_ready), 32'h1);
        chk("mid_rst_flat", reg_flat, 32'h0);
        chk("mid_rst_rd0", 32'(rd0_data), 32'h0);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("mid_no_done", 32'(clr_done), 32'h0);
        end

        // DEPTH=3 instance: out-of-range write and read.
        t3_wr_valid = 1'b1;
        t3_wr_addr  = 2'd2;
        t3_wr_data  = 8'h77;
        cyc();
        t3_wr_valid = 1'b0;
        chk("t3_err_inrange", 32'(t3_wr_err), 32'h0);
        chk("t3_flat_wr", 32'(t3_reg_flat), 32'h00770000);
        t3_wr_valid = 1'b1;
        t3_wr_addr  = 2'd3;
        t3_wr_data  = 8'h5A;
        cyc();
        t3_wr_valid = 1'b0;
        chk("t3_err_pulse", 32'(t3_wr_err), 32'h1);
        chk("t3_flat_keep", 32'(t3_reg_flat), 32'h00770000);
        cyc();
        chk("t3_err_clear", 32'(t3_wr_err), 32'h0);
        t3_rd0_en   = 1'b1;
        t3_rd0_addr = 2'd2;
        cyc();
        chk("t3_rd_inrange", 32'(t3_rd0_data), 32'h00000077);
        t3_rd0_addr = 2'd3;
        cyc();
        t3_rd0_en = 1'b0;
        chk("t3_rd_oob", 32'(t3_rd0_data), 32'h0);

        cyc();
        chk("sb_drain", 32'(exp0_q.size() + exp1_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
